hamming_11_7_dec: RTL and testbench

Pipelined Hamming(11,7) single-error-correcting decoder. It accepts 11-bit codewords from the `hamming_11_7` encoder's channel through a valid/ready handshake and returns the 7 data bits with correction status. It keeps saturating counts of corrected and uncorrectable words. It sits at the receive end of every link protected by the 11,7 encoder.

---
 rtl/hamming_11_7_dec.sv | 139 +++++++++++++
 tb/tb_hamming_11_7_dec.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_11_7_dec.sv
// Two-stage pipelined Hamming(11,7) single-error-correcting decoder with
// valid/ready flow control and saturating corrected/uncorrectable word counters.
module hamming_11_7_dec #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_data,
  output logic [3:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  function automatic logic [3:0] calc_syn(input logic [10:0] c);
    logic [3:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    s[2] = ^c[6:3];
    s[3] = ^c[10:7];
    return s;
  endfunction

  // Syndromes 12..15 point outside the word, so they leave it untouched.
  function automatic logic [10:0] correct(input logic [10:0] c, input logic [3:0] s);
    logic [10:0] mask;
    mask = '0;
    if ((s != 4'd0) && (s <= 4'd11))
      mask = 11'd1 << (s - 4'd1);
    return c ^ mask;
  endfunction

  function automatic logic [6:0] extract(input logic [10:0] c);
    return {c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [10:0]      s1_code_q, s1_code_d;
  logic [3:0]       s1_syn_q, s1_syn_d;
  logic             out_valid_q, out_valid_d;
  logic [6:0]       out_data_q, out_data_d;
  logic [3:0]       out_syn_q, out_syn_d;
  logic             out_corr_q, out_corr_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic s2_load, s1_load, s1_take, xfer, s1_corr, s1_uncorr;

  always_comb begin
    s2_load   = !out_valid_q || out_ready;
    s1_load   = !s1_valid_q || s2_load;
    s1_take   = s1_load && in_valid;
    xfer      = s2_load && s1_valid_q;
    s1_corr   = (s1_syn_q != 4'd0) && (s1_syn_q <= 4'd11);
    s1_uncorr = (s1_syn_q >= 4'd12);

    // Stage 1: capture the received word and its syndrome
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (s1_take) begin
      s1_code_d = in_code;
      s1_syn_d  = calc_syn(in_code);
    end

    // Stage 2: corrected data and status, held while stalled
    out_valid_d  = s2_load ? s1_valid_q : out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (xfer) begin
      out_data_d   = extract(correct(s1_code_q, s1_syn_q));
      out_syn_d    = s1_syn_q;
      out_corr_d   = s1_corr;
      out_uncorr_d = s1_uncorr;
    end

    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clear) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (xfer) begin
      if (s1_corr)   corr_cnt_d   = sat_inc(corr_cnt_q);
      if (s1_uncorr) uncorr_cnt_d = sat_inc(uncorr_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_code_q <= s1_code_d;
    s1_syn_q  <= s1_syn_d;
  end

  assign in_ready      = s1_load;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_syndrome  = out_syn_q;
  assign out_corrected = out_corr_q;
  assign out_uncorr    = out_uncorr_q;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_11_7_dec.sv
// Randomized and directed bench for hamming_11_7_dec against a position-based
// Hamming model (syndrome = XOR of the 1-based positions of all set bits).
module tb_hamming_11_7_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] in_code;
  logic        in_valid, in_ready, out_ready, cnt_clear;
  logic [6:0]  out_data;
  logic [3:0]  out_syndrome;
  logic        out_corrected, out_uncorr, out_valid;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic        sat_in_ready, sat_out_corrected, sat_out_uncorr, sat_out_valid;
  logic [6:0]  sat_out_data;
  logic [3:0]  sat_out_syndrome;
  logic [1:0]  sat_corr_cnt, sat_uncorr_cnt;

  always #5 clk = ~clk;

  hamming_11_7_dec #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorr(out_uncorr), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clear(cnt_clear), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt));

  hamming_11_7_dec #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid), .in_ready(sat_in_ready),
    .out_data(sat_out_data), .out_syndrome(sat_out_syndrome), .out_corrected(sat_out_corrected),
    .out_uncorr(sat_out_uncorr), .out_valid(sat_out_valid), .out_ready(out_ready),
    .cnt_clear(cnt_clear), .corr_cnt(sat_corr_cnt), .uncorr_cnt(sat_uncorr_cnt));

  int n_vec = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];
  int m_corr = 0;
  int m_uncorr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_syn(input logic [10:0] c);
    int s = 0;
    for (int i = 0; i < 11; i++) if (c[i]) s ^= (i + 1);
    return s[3:0];
  endfunction

  function automatic logic [6:0] m_data(input logic [10:0] c);
    logic [10:0] w;
    logic [6:0] d;
    int s, k;
    s = int'(m_syn(c));
    w = c;
    if (s >= 1 && s <= 11) w[s-1] = ~w[s-1];
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 11; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[k] = w[pos-1];
        k++;
      end
    return d;
  endfunction

  function automatic logic [10:0] enc(input logic [6:0] d);
    logic [10:0] w;
    logic [3:0] s;
    int k;
    w = '0;
    k = 0;
    for (int pos = 1; pos <= 11; pos++)
      if ((pos & (pos - 1)) != 0) begin
        w[pos-1] = d[k];
        k++;
      end
    s = m_syn(w);
    w[0] = s[0]; w[1] = s[1]; w[3] = s[2]; w[7] = s[3];
    return w;
  endfunction

  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare process: scoreboard on every output transfer, stability while stalled.
  logic       stall_prev = 1'b0;
  logic [6:0] prev_data;
  logic [3:0] prev_syn;
  logic       prev_corr, prev_uncorr;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {25'd0, out_data}, {25'd0, prev_data});
        chk("hold_syn", {28'd0, out_syndrome}, {28'd0, prev_syn});
        chk("hold_flags", {30'd0, out_corrected, out_uncorr}, {30'd0, prev_corr, prev_uncorr});
      end
      if (sat_in_ready !== in_ready) chk("in_ready_twin", {31'd0, sat_in_ready}, {31'd0, in_ready});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("dup_word", {31'd0, out_valid}, 32'd0);
        end else begin
          logic [10:0] c;
          logic [3:0]  s;
          c = exp_q.pop_front();
          s = m_syn(c);
          chk("data", {25'd0, out_data}, {25'd0, m_data(c)});
          chk("syn", {28'd0, out_syndrome}, {28'd0, s});
          chk("corr", {31'd0, out_corrected}, {31'd0, (s >= 4'd1 && s <= 4'd11)});
          chk("uncorr", {31'd0, out_uncorr}, {31'd0, (s >= 4'd12)});
          chk("sat_data", {20'd0, sat_out_valid, sat_out_data, sat_out_syndrome},
              {20'd0, 1'b1, m_data(c), s});
          chk("sat_flags", {30'd0, sat_out_corrected, sat_out_uncorr},
              {30'd0, (s >= 4'd1 && s <= 4'd11), (s >= 4'd12)});
          if (s >= 4'd1 && s <= 4'd11) m_corr++;
          if (s >= 4'd12) m_uncorr++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_code);
      stall_prev  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_syn    = out_syndrome;
      prev_corr   = out_corrected;
      prev_uncorr = out_uncorr;
    end
  end

  task automatic send(input logic [10:0] c);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_code  = c;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("send_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_corr"}, {16'd0, corr_cnt}, satv(m_corr, 65535));
    chk({tag, "_uncorr"}, {16'd0, uncorr_cnt}, satv(m_uncorr, 65535));
    chk({tag, "_sat_corr"}, {30'd0, sat_corr_cnt}, satv(m_corr, 3));
    chk({tag, "_sat_uncorr"}, {30'd0, sat_uncorr_cnt}, satv(m_uncorr, 3));
  endtask

  initial begin
    logic [10:0] w[4];
    int acc, idx, sent;
    logic take;

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clear = 1'b0;

    chk("pin_syn_clean", {28'd0, m_syn(11'h52F)}, 32'd0);
    chk("pin_data_clean", {25'd0, m_data(11'h52F)}, 32'h55);
    chk("pin_enc", {21'd0, enc(7'h55)}, 32'h52F);
    chk("pin_syn_single", {28'd0, m_syn(11'h53F)}, 32'd5);
    chk("pin_syn_uncorr", {28'd0, m_syn(11'h5A7)}, 32'd12);
    chk("pin_data_uncorr", {25'd0, m_data(11'h5A7)}, 32'h55);

    #3;
    chk("reset_outs", {20'd0, out_valid, out_data, out_syndrome}, 32'd0);
    chk("reset_flags", {30'd0, out_corrected, out_uncorr}, 32'd0);
    chk("reset_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Clean word, latency through both register stages
    in_valid = 1'b1; in_code = 11'h52F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_stage1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {25'd0, out_data}, 32'h55);
    chk("lat_syn_flags", {26'd0, out_syndrome, out_corrected, out_uncorr}, 32'd0);
    drain();
    chk_cnt("clean");

    // Single-bit error sweep, back to back
    for (int i = 0; i < 11; i++) begin
      chk("pin_sweep_syn", {28'd0, m_syn(11'h52F ^ (11'd1 << i))}, i + 1);
      chk("pin_sweep_data", {25'd0, m_data(11'h52F ^ (11'd1 << i))}, 32'h55);
      send(11'h52F ^ (11'd1 << i));
    end
    drain();
    chk_cnt("sweep");

    send(11'h5A7);
    drain();
    chk_cnt("uncorr");

    // Backpressure: two accepts then stall
    w[0] = 11'h53F; w[1] = 11'h52F; w[2] = 11'h5A7; w[3] = enc(7'h2A) ^ 11'h400;
    out_ready = 1'b0; acc = 0; idx = 0;
    in_valid = 1'b1; in_code = w[0];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #1;
      if (take) begin
        acc++; idx++;
        if (idx < 4) in_code = w[idx]; else in_valid = 1'b0;
      end
    end
    chk("bp_accepts", acc, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out", {24'd0, out_valid, out_data}, {24'd0, 1'b1, m_data(w[0])});
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idx++;
    while (idx < 4) begin
      send(w[idx]);
      idx++;
    end
    drain();
    chk_cnt("bp");

    // Saturation from zero, then clear racing an increment
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    m_corr = 0; m_uncorr = 0;
    chk("clear_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) send(11'h53F);
    drain();
    chk("sat_stop", {30'd0, sat_corr_cnt}, 32'd3);
    chk_cnt("sat");
    in_valid = 1'b1; in_code = 11'h53F;
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clear_wins", {14'd0, sat_corr_cnt, corr_cnt}, 32'd0);
    chk("clear_word_out", {30'd0, out_valid, out_corrected}, 32'd3);
    drain();
    m_corr = 0; m_uncorr = 0;
    chk_cnt("after_clear");

    // Randomized traffic with random backpressure
    sent = 0;
    for (int cyc = 0; cyc < 6000 && sent < 400; cyc++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && ($urandom % 4) != 0) begin
        case ($urandom % 3)
          0: in_code = enc(7'($urandom));
          1: in_code = enc(7'($urandom)) ^ (11'd1 << ($urandom % 11));
          default: in_code = 11'($urandom);
        endcase
        in_valid = 1'b1;
      end
      out_ready = ($urandom % 4) != 0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", {31'd0, sent == 400}, 32'd1);
    drain();
    chk_cnt("rand");

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 11'h53F;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_before_reset", {30'd0, out_valid, in_ready}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    chk("async_rst_sat", {28'd0, sat_corr_cnt, sat_uncorr_cnt}, 32'd0);
    exp_q.delete();
    m_corr = 0; m_uncorr = 0;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_code = 11'h53F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_word", {21'd0, out_valid, out_data, out_syndrome},
        {21'd0, 1'b1, 7'h55, 4'd5});
    chk("post_rst_corr", {31'd0, out_corrected}, 32'd1);
    drain();
    chk_cnt("post_rst");
    chk("leftover_words", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
